hilo_muldiv_sequencer: RTL
==========================

// Module: hilo_muldiv_sequencer
// PURPOSE
//  Multi-cycle MULT/MULTU/DIV/DIVU engine owning the HI/LO registers; also services MTHI/MTLO.
//  Takes the decoded 5-bit ALU control code plus operands from the execute stage.
//  Back-pressures new ops via req_ready; stalls MFHI/MFLO reads while an op is in flight.
// PARAMETERS
//  WIDTH  32  operand width; HI/LO each WIDTH bits; iteration count = WIDTH (must be even, >=4)
// PORTS
//  clk          in   1      rising-edge clock
//  reset        in   1      synchronous, active-high
//  req_valid    in   1      op present on op/operand_a/operand_b
//  req_ready    out  1      high only in IDLE; op accepted on edge where valid&&ready
//  op           in   5      alu_control code: MULT 10000, MULTU 10001, DIV 10010, DIVU 10011, MTLO 10101, MTHI 10110
//  operand_a    in   WIDTH  rs: multiplicand / dividend / MTHI-MTLO data
//  operand_b    in   WIDTH  rt: multiplier / divisor
//  rd_hi_req    in   1      MFHI in execute
//  rd_lo_req    in   1      MFLO in execute
//  stall        out  1      busy && (rd_hi_req || rd_lo_req), combinational
//  busy         out  1      state != IDLE
//  hi           out  WIDTH  HI register
//  lo           out  WIDTH  LO register
// BEHAVIOUR
//  Reset: state=IDLE, hi=lo=0, counter=0, busy=0, req_ready=1; reset mid-op aborts, result discarded.
//  FSM IDLE -> MUL_RUN | DIV_RUN -> FIX -> IDLE.
//  IDLE, accept MTHI/MTLO: hi (or lo) <= operand_a at accept edge; stay IDLE; other register unchanged.
//  IDLE, accept codes other than the six listed: consumed, no effect, stay IDLE.
//  IDLE, accept MULT*/DIV*: latch |a|,|b| (signed ops) or raw a,b (unsigned); latch neg_q = sign(a)^sign(b),
//   neg_r = sign(a); counter <= WIDTH; go to RUN.
//  MUL_RUN: radix-2 shift-add, one bit/edge, counter decrements; at counter==1 go FIX.
//  DIV_RUN: restoring division, one quotient bit/edge; same counting.
//  Iteration edges 1..WIDTH after accept; FIX at edge WIDTH+1 writes hi/lo and returns IDLE (busy falls same edge).
//  FIX: MULT: 2*WIDTH product negated if neg_q; hi=upper, lo=lower. DIV: lo=quotient (negated if neg_q),
//   hi=remainder (negated if neg_r). Unsigned ops: no negation.
//  Abs of INT_MIN is 2^(WIDTH-1) unsigned; DIV INT_MIN/-1 yields lo=INT_MIN, hi=0 (wrap, no trap).
//  Divide by zero (DIV or DIVU, b==0): skip RUN; IDLE -> FIX; at edge 1: hi=operand_a (raw), lo=all-ones.
//  All writes to hi/lo occur only at FIX or an MT* accept; hi/lo hold otherwise.
//  req_valid while busy: req_ready=0, requester holds; no queueing.
//  stall is independent of req_valid; clears combinationally when busy drops, so MFHI/MFLO
//   in the cycle after FIX see the new values.
// CONFIGURATION
//  MULDIV_FAST_MULT_EN defined: MULT/MULTU use a single-cycle WIDTHxWIDTH product registered at edge 1
//   (MUL_RUN lasts one edge), FIX at edge 2. Divide unchanged.
//  Undefined: iterative shift-add multiply, WIDTH+1 edge latency as above.
// STRUCTURE
//  Shared package mips_pkg: alu_control_t enum (CONTROL_MULT..CONTROL_MTHI, codes above, reused by decoder),
//   muldiv_state_t {IDLE, MUL_RUN, DIV_RUN, FIX}.
//  Sub-module muldiv_iter_core: shift-add / restoring-divide datapath (acc, operand regs, step/load inputs);
//   sequencer keeps FSM, counter, sign fix-up and HI/LO.
// TESTING
//  MULTU 0xFFFFFFFF*0xFFFFFFFF -> req_ready=0 for 33 cycles, then hi=0xFFFFFFFE, lo=0x00000001.
//  MULT -3*5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
//  DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/2 -> lo=3, hi=1; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
//  DIVU 0x1234/0 -> busy one cycle, hi=0x00001234, lo=0xFFFFFFFF after edge 1.
//  MTHI 0xDEADBEEF in IDLE -> hi=0xDEADBEEF next cycle, lo unchanged; MTLO while busy -> held until ready.
//  rd_lo_req held during DIVU -> stall=1 every busy cycle, 0 after FIX; reset at iteration 10 -> hi=lo=0, req_ready=1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS execute-stage definitions: ALU control codes and HI/LO mul/div sequencer states.
package mips_pkg;

   typedef enum logic [4:0] {
      CONTROL_MULT  = 5'b10000,
      CONTROL_MULTU = 5'b10001,
      CONTROL_DIV   = 5'b10010,
      CONTROL_DIVU  = 5'b10011,
      CONTROL_MTLO  = 5'b10101,
      CONTROL_MTHI  = 5'b10110
   } alu_control_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MUL_RUN = 2'd1,
      DIV_RUN = 2'd2,
      FIX     = 2'd3
   } muldiv_state_t;

endpackage

// File: rtl/muldiv_iter_core.sv
// Shared shift-add multiply / restoring divide datapath, one bit per step.
// Product layout: upper half = accumulator/remainder, lower half = multiplier/dividend-quotient.
module muldiv_iter_core #(
   parameter int WIDTH     = 32,
   parameter bit FAST_MULT = 1'b0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load_i,
   input  logic               step_i,
   input  logic               div_mode_i,
   input  logic [WIDTH-1:0]   load_lo_i,
   input  logic [WIDTH-1:0]   load_opnd_i,
   output logic [2*WIDTH-1:0] prod_o
);

   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic [WIDTH:0]     add_sum;
   logic [WIDTH:0]     shifted;
   logic [WIDTH:0]     diff;

   always_comb begin
      prod_d  = prod_q;
      opnd_d  = opnd_q;
      add_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
      shifted = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
      diff    = shifted - {1'b0, opnd_q};
      if (load_i) begin
         prod_d = {{WIDTH{1'b0}}, load_lo_i};
         opnd_d = load_opnd_i;
      end else if (step_i) begin
         if (div_mode_i) begin
            // borrow out of the W+1-bit subtract means the divisor did not fit: restore
            if (!diff[WIDTH])
               prod_d = {diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
            else
               prod_d = {shifted[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
         end else if (FAST_MULT) begin
            prod_d = {{WIDTH{1'b0}}, opnd_q} * {{WIDTH{1'b0}}, prod_q[WIDTH-1:0]};
         end else begin
            prod_d = {add_sum, prod_q[WIDTH-1:1]};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prod_q <= '0;
         opnd_q <= '0;
      end else begin
         prod_q <= prod_d;
         opnd_q <= opnd_d;
      end
   end

   assign prod_o = prod_q;

endmodule

// File: rtl/hilo_muldiv_sequencer.sv
// HI/LO owner: sequences MULT/MULTU/DIV/DIVU through muldiv_iter_core and services MTHI/MTLO.
// Build option MULDIV_FAST_MULT_EN: single-cycle multiply product instead of shift-add.
//
// state   | meaning
// IDLE    | ready for a new op; MTHI/MTLO write here
// MUL_RUN | multiply iterating (one edge when fast multiply is built in)
// DIV_RUN | restoring divide, one quotient bit per edge
// FIX     | sign fix-up, HI/LO write, return to IDLE
module hilo_muldiv_sequencer
   import mips_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [4:0]       op,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic             rd_hi_req,
   input  logic             rd_lo_req,
   output logic             stall,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

`ifdef MULDIV_FAST_MULT_EN
   localparam bit FAST_MULT = 1'b1;
`else
   localparam bit FAST_MULT = 1'b0;
`endif

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

   muldiv_state_t      state_q, state_d;
   logic [CW-1:0]      counter_q, counter_d;
   logic               neg_quot_q, neg_quot_d;
   logic               neg_rem_q, neg_rem_d;
   logic               is_div_q, is_div_d;
   logic               div_zero_q, div_zero_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;

   alu_control_t       op_e;
   logic               signed_op, a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic               core_load, core_step;
   logic [WIDTH-1:0]   load_lo, load_opnd;
   logic [2*WIDTH-1:0] core_prod, prod_fix;
   logic [WIDTH-1:0]   quot, rem;

   assign op_e      = alu_control_t'(op);
   assign signed_op = (op_e == CONTROL_MULT) || (op_e == CONTROL_DIV);
   assign a_neg     = signed_op && operand_a[WIDTH-1];
   assign b_neg     = signed_op && operand_b[WIDTH-1];
   // INT_MIN negates to itself, which read unsigned is exactly 2^(WIDTH-1)
   assign a_mag     = a_neg ? -operand_a : operand_a;
   assign b_mag     = b_neg ? -operand_b : operand_b;

   assign prod_fix  = neg_quot_q ? -core_prod : core_prod;
   assign quot      = core_prod[WIDTH-1:0];
   assign rem       = core_prod[2*WIDTH-1:WIDTH];

   always_comb begin
      state_d    = state_q;
      counter_d  = counter_q;
      neg_quot_d = neg_quot_q;
      neg_rem_d  = neg_rem_q;
      is_div_d   = is_div_q;
      div_zero_d = div_zero_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      core_load  = 1'b0;
      core_step  = 1'b0;
      load_lo    = b_mag;
      load_opnd  = a_mag;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               case (op_e)
                  CONTROL_MTHI: hi_d = operand_a;
                  CONTROL_MTLO: lo_d = operand_a;
                  CONTROL_MULT, CONTROL_MULTU: begin
                     core_load  = 1'b1;
                     neg_quot_d = a_neg ^ b_neg;
                     neg_rem_d  = a_neg;
                     is_div_d   = 1'b0;
                     div_zero_d = 1'b0;
                     counter_d  = FAST_MULT ? CNT_ONE : CNT_FULL;
                     state_d    = MUL_RUN;
                  end
                  CONTROL_DIV, CONTROL_DIVU: begin
                     core_load  = 1'b1;
                     neg_quot_d = a_neg ^ b_neg;
                     neg_rem_d  = a_neg;
                     is_div_d   = 1'b1;
                     if (operand_b == '0) begin
                        // raw dividend parks in the core's low half until FIX copies it to HI
                        div_zero_d = 1'b1;
                        load_lo    = operand_a;
                        load_opnd  = '0;
                        state_d    = FIX;
                     end else begin
                        div_zero_d = 1'b0;
                        load_lo    = a_mag;
                        load_opnd  = b_mag;
                        counter_d  = CNT_FULL;
                        state_d    = DIV_RUN;
                     end
                  end
                  default: ;
               endcase
            end
         end
         MUL_RUN, DIV_RUN: begin
            core_step = 1'b1;
            counter_d = counter_q - CNT_ONE;
            if (counter_q == CNT_ONE)
               state_d = FIX;
         end
         FIX: begin
            if (!is_div_q) begin
               {hi_d, lo_d} = prod_fix;
            end else if (div_zero_q) begin
               hi_d = quot;
               lo_d = '1;
            end else begin
               lo_d = neg_quot_q ? -quot : quot;
               hi_d = neg_rem_q ? -rem : rem;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         counter_q  <= '0;
         neg_quot_q <= 1'b0;
         neg_rem_q  <= 1'b0;
         is_div_q   <= 1'b0;
         div_zero_q <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
      end else begin
         state_q    <= state_d;
         counter_q  <= counter_d;
         neg_quot_q <= neg_quot_d;
         neg_rem_q  <= neg_rem_d;
         is_div_q   <= is_div_d;
         div_zero_q <= div_zero_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
      end
   end

   muldiv_iter_core #(
      .WIDTH     (WIDTH),
      .FAST_MULT (FAST_MULT)
   ) u_core (
      .clk         (clk),
      .reset       (reset),
      .load_i      (core_load),
      .step_i      (core_step),
      .div_mode_i  (is_div_d),
      .load_lo_i   (load_lo),
      .load_opnd_i (load_opnd),
      .prod_o      (core_prod)
   );

   assign busy      = (state_q != IDLE);
   assign req_ready = (state_q == IDLE);
   assign stall     = busy && (rd_hi_req || rd_lo_req);
   assign hi        = hi_q;
   assign lo        = lo_q;

endmodule
